// File: rtl/sseg_scan_ctrl_if.sv
// rtl/sseg_scan_ctrl_if.sv - load/control inputs and display pins of the seven-segment scan controller
interface sseg_scan_ctrl_if #(
    parameter int DIGITS = 4
) ();
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_blank;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_tick;

    modport master (
        output en, load, value, dp_in, lz_blank,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  en, load, value, dp_in, lz_blank,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - double-buffered, ghost-guarded scan controller for a common-anode seven-segment display
module sseg_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    // {g,f,e,d,c,b,a}, active-low
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module sseg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SLOT_CYC  = 100000,
    parameter int BLANK_CYC = 2000
) (
    input logic             clk,
    input logic             rst_n,
    sseg_scan_ctrl_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int VAL_W = 4 * DIGITS;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(SLOT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               boundary;

    logic [VAL_W-1:0]   active_val;
    logic [DIGITS-1:0]  active_dp;
    logic [VAL_W-1:0]   pend_val;
    logic [DIGITS-1:0]  pend_dp;
    logic               pend_valid;

    logic [3:0]         nibble;
    logic [6:0]         dec_seg;
    logic               suppress;
    logic [DIGITS-1:0]  an_nxt;
    logic [6:0]         seg_nxt;
    logic               dp_nxt;

    // One counter spans the whole slot: blank phase first, then the lit phase.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        boundary  = 1'b0;
        if (!bus.en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_END) begin
                        state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_END) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == LAST_IDX) begin
                            idx_nxt  = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are computed from the next state so anode and segments switch together.
    assign nibble = active_val[{idx_nxt, 2'b00} +: 4];

    sseg_decoder u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        suppress = bus.lz_blank && (idx_nxt != '0) &&
                   ((active_val >> {idx_nxt, 2'b00}) == '0);
        an_nxt   = '1;
        seg_nxt  = 7'h7F;
        dp_nxt   = 1'b1;
        if (state_nxt == SHOW) begin
            an_nxt  = ~(DIGITS'(1) << idx_nxt);
            seg_nxt = suppress ? 7'h7F : dec_seg;
            dp_nxt  = ~active_dp[idx_nxt];
        end
    end

    // Transfer reads the pre-edge pending copy, so a same-edge load waits one frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_val     <= '0;
            active_dp      <= '0;
            pend_val       <= '0;
            pend_dp        <= '0;
            pend_valid     <= 1'b0;
            bus.an         <= '1;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an         <= an_nxt;
            bus.seg        <= seg_nxt;
            bus.dp         <= dp_nxt;
            bus.frame_tick <= boundary;
            if (boundary && pend_valid) begin
                active_val <= pend_val;
                active_dp  <= pend_dp;
            end
            if (bus.load) begin
                pend_val   <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - scoreboard bench for sseg_scan_ctrl against a frame-position reference model
module tb_sseg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * SLOT;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sseg_scan_ctrl_if #(.DIGITS(DIGITS)) ifc ();

    sseg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SLOT_CYC  (SLOT),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mon_cyc = 0;

    logic c_rst = 1'b0;
    logic c_en  = 1'b1;
    logic c_lz  = 1'b0;

    bit          m_run  = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_act  = '0;
    logic [3:0]  m_act_dp = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_pend_dp = '0;
    bit          m_pv   = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, mon_cyc, act, exp);
        end
    endfunction

    // Expected display derived from the position within the frame since scanning started.
    task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d);
        exp_t        e;
        int          p, slot, off;
        logic [15:0] upper;
        rst_n        = c_rst;
        ifc.en       = c_en;
        ifc.load     = ld;
        ifc.value    = v;
        ifc.dp_in    = d;
        ifc.lz_blank = c_lz;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.ft  = 1'b0;
        if (!c_rst) begin
            m_run = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 0;
        end else if (!c_en) begin
            m_run = 0;
            if (ld) begin m_pend = v; m_pend_dp = d; m_pv = 1; end
        end else begin
            if (m_run) m_t++;
            else begin m_run = 1; m_t = 0; end
            p = m_t % FRAME;
            if (p == 0) begin
                e.ft = 1'b1;
                if (m_pv) begin m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 0; end
            end
            if (ld) begin m_pend = v; m_pend_dp = d; m_pv = 1; end
            slot = p / SLOT;
            off  = p % SLOT;
            if (off >= BLANK) begin
                e.an  = ~(4'b0001 << slot);
                upper = m_act >> (4 * slot);
                e.seg = (c_lz && slot > 0 && upper == 16'h0) ? 7'h7F : seg_tab[upper[3:0]];
                e.dp  = ~m_act_dp[slot];
            end
        end
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic wait_lit(input int s);
        int k = 0;
        while (!(m_run && ((m_t % FRAME) / SLOT) == s && (m_t % SLOT) >= BLANK) && k < 3 * FRAME) begin
            idle_n(1);
            k++;
        end
        check("wait_lit_bound", 32'(k < 3 * FRAME), 32'd1);
    endtask

    task automatic wait_pos(input int pos);
        int k = 0;
        while (!(m_run && (m_t % FRAME) == pos) && k < 3 * FRAME) begin
            idle_n(1);
            k++;
        end
        check("wait_pos_bound", 32'(k < 3 * FRAME), 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        mon_cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("an", 32'(ifc.an), 32'(e.an));
            check("seg", 32'(ifc.seg), 32'(e.seg));
            check("dp", 32'(ifc.dp), 32'(e.dp));
            check("frame_tick", 32'(ifc.frame_tick), 32'(e.ft));
        end
    end

    initial begin
        rst_n = 1'b0;
        ifc.en = 1'b1; ifc.load = 1'b0; ifc.value = '0; ifc.dp_in = '0; ifc.lz_blank = 1'b0;

        c_rst = 1'b0; c_en = 1'b1;
        idle_n(3);
        c_rst = 1'b1;
        idle_n(10);

        tick(1'b1, 16'h1A30, 4'b0100);
        idle_n(2 * FRAME + 4);

        wait_lit(2);
        tick(1'b1, 16'h2222, 4'b0000);
        idle_n(FRAME + 8);
        wait_pos(FRAME - 1);
        tick(1'b1, 16'hC5E7, 4'b1010);
        idle_n(2 * FRAME + 2);

        c_lz = 1'b1;
        tick(1'b1, 16'h0050, 4'b1000);
        idle_n(2 * FRAME);
        tick(1'b1, 16'h0000, 4'b0000);
        idle_n(2 * FRAME);
        c_lz = 1'b0;
        idle_n(FRAME);

        wait_lit(1);
        c_en = 1'b0;
        idle_n(3);
        tick(1'b1, 16'hBEEF, 4'b1001);
        idle_n(4);
        c_en = 1'b1;
        idle_n(FRAME + 4);

        wait_lit(3);
        c_rst = 1'b0;
        idle_n(1);
        c_rst = 1'b1;
        idle_n(FRAME + 6);
        tick(1'b1, 16'h9D4B, 4'b0110);
        idle_n(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            c_rst = ($urandom_range(0, 399) != 0);
            c_en  = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 99) == 0) c_lz = ~c_lz;
            tick(($urandom_range(0, 29) == 0), 16'($urandom), 4'($urandom));
        end
        c_rst = 1'b1; c_en = 1'b1;
        idle_n(FRAME);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a DIGITS-wide, common-anode seven-segment display.
- Cycles through the digits one at a time.
- Feeds each digit's nibble into an internal sseg_decoder instance and drives the matching active-low anode.
- Inserts a ghost-guard blank interval between digits.
- Double-buffers the displayed value so a load only takes effect at a frame boundary (no tearing).
- Sits between the board's 16-bit result registers and the display pins.

Parameters:
- DIGITS, 4, number of digits scanned; value width is 4*DIGITS.
- SLOT_CYC, 100000, clk cycles per digit slot, blank interval included; must be > BLANK_CYC.
- BLANK_CYC, 2000, clk cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scan enable; 0 = display dark.
- load  input  1  one-cycle strobe; captures value and dp_in into the pending buffer.
- value  input  4*DIGITS  hex nibbles; digit 0 = bits [3:0] (rightmost).
- dp_in  input  DIGITS  decimal-point request per digit, active-high.
- lz_blank  input  1  1 = suppress leading zeros.
- an  output  DIGITS  anode enables, active-low, registered.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered; taken from the sseg_decoder output.
- dp  output  1  decimal point, active-low, registered.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: rst_n sampled low on a rising clk edge resets the block.
- Reset values:
  - an = all 1s, seg = 7'h7F, dp = 1, frame_tick = 0.
  - state = IDLE, digit index = 0, slot counter = 0.
  - active and pending buffers = 0, pend_valid = 0.
- Reset mid-slot takes effect on that edge with no partial frame afterwards.
- States:
  - IDLE: all outputs dark.
    - en=1 -> BLANK at index 0, counter cleared.
  - BLANK: an all 1s, seg 7'h7F, dp 1.
    - Counter runs 0..BLANK_CYC-1, then -> SHOW.
  - SHOW: exactly one anode low (an[idx]=0), for SLOT_CYC-BLANK_CYC cycles.
    - At the end -> BLANK with idx+1.
    - idx DIGITS-1 wraps to 0.
  - From any state, en=0 sampled -> IDLE on that edge; outputs go dark the same edge.
    - Re-enable always restarts at digit 0 in BLANK.
- Frame boundary = entry into BLANK with idx 0, from IDLE or from the wrap.
  - frame_tick=1 for exactly that one cycle.
  - If pend_valid: active <= pending, pend_valid <= 0, on the same edge.
- Load buffering:
  - load=1 writes {value, dp_in} into pending and sets pend_valid; a later load before the boundary overwrites.
  - A load on the boundary edge goes to pending and is shown next frame. The transfer uses the pre-edge pending contents.
  - A load while en=0 transfers when scanning next starts.
- Digit data in SHOW:
  - nibble = active[4*idx+3:4*idx].
  - seg = sseg_decoder(nibble). Examples: 0 -> 7'b1000000, 1 -> 7'b1111001, A -> 7'b0001000, F -> 7'b0001110.
  - dp = ~active_dp[idx].
- Leading-zero suppression, with lz_blank=1:
  - A digit idx>0 whose nibble and all higher nibbles are 0 shows seg 7'h7F. Its anode is still driven low.
  - dp still follows dp_in for a suppressed digit.
  - Digit 0 is never suppressed.
  - lz_blank is sampled live, not buffered.
- Timing: an, seg and dp change on the same edge. There is no cycle in which an anode is low with the previous digit's segments.
- Frame period = DIGITS*SLOT_CYC cycles.

Test Plan:
Params DIGITS=4, SLOT_CYC=8, BLANK_CYC=2.
1. Reset/enable: rst_n=0 for 3 cycles with en=1.
   - Expect an=4'hF, seg=7'h7F, dp=1, frame_tick=0 throughout.
   - After release: frame_tick at cycle 1, an=4'hF for 2 cycles, then an=4'b1110 for 6 cycles.
2. Scan pattern: load value=16'h1A30, dp_in=4'b0100, then run 2 frames.
   - Second frame shows an=1110 seg=1000000 dp=1; an=1101 seg=0110000; an=1011 seg=0001000 dp=0; an=0111 seg=1111001.
   - Each slot has 2 dark cycles and 6 lit cycles; frame_tick is spaced 32 cycles apart.
3. Tear-free load: load 16'h2222 at mid-frame (digit 2 lit).
   - Digits 2 and 3 keep the old value.
   - 16'h2222 (seg=0100100) appears from the next frame_tick onward.
   - Load coinciding with frame_tick shows the value one frame later.
4. Leading zeros: value=16'h0050 with lz_blank=1.
   - Digits 3 and 2 give seg=7'h7F; digit 1 gives 0010010; digit 0 gives 1000000.
   - value=16'h0000 shows only digit 0 as "0".
   - With lz_blank=0, all four digits show "0".
5. Disable mid-slot: drop en while digit 1 is lit.
   - Next edge: an=4'hF, seg=7'h7F.
   - Re-enable: frame_tick and restart at digit 0 BLANK. A pending load made while disabled is shown.
6. Reset mid-operation: assert rst_n=0 while digit 3 is lit.
   - Next edge: all outputs dark, active buffer cleared.
   - After release, digits show "0" until the next load plus frame boundary.
